projectile_pool: RTL and testbench

Parametrised successor to the single-bullet logic in game_state_updater. Manages a pool of NUM_SLOTS independent projectiles on the GRID_W x GRID_H playfield.
- Spawns on a debounced fire edge from the nunchuk path (z).
- Advances all live projectiles on a bullet-rate step pulse.
- Retires projectiles at the far edge or on a kill request from the collision logic.
- Outputs feed the VGA renderer and the collision checker.

---
 rtl/game_pkg.sv | 23 ++
 rtl/projectile_slot.sv | 79 +++++++
 rtl/projectile_pool.sv | 166 ++++++++++++++++
 tb/tb_projectile_pool.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared playfield types, defaults and FSM encodings for the projectile pool.
package game_pkg;

    localparam int unsigned DEF_GRID_W  = 16;
    localparam int unsigned DEF_GRID_H  = 16;
    localparam int unsigned DEF_COLOR_W = 12;

    // Width of an index able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_X_W = clog2_min1(DEF_GRID_W);
    localparam int unsigned DEF_Y_W = clog2_min1(DEF_GRID_H);

    typedef logic [DEF_X_W-1:0]     coord_x_t;
    typedef logic [DEF_Y_W-1:0]     coord_y_t;
    typedef logic [DEF_COLOR_W-1:0] color_t;

    typedef enum logic {READY = 1'b0, COOLDOWN = 1'b1} fire_state_e;
    typedef enum logic {IDLE  = 1'b0, FLYING   = 1'b1} slot_state_e;

endpackage

// File: rtl/projectile_slot.sv
// One projectile: spawns at x=0, advances one column per step, retires at the far edge or on kill.
module projectile_slot
    import game_pkg::*;
#(
    parameter  int unsigned GRID_W  = DEF_GRID_W,
    parameter  int unsigned X_W     = clog2_min1(GRID_W),
    parameter  int unsigned Y_W     = DEF_Y_W,
    parameter  int unsigned COLOR_W = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_spawn,
    input  logic               i_step,
    input  logic               i_kill,
    input  logic [Y_W-1:0]     i_y,
    input  logic [COLOR_W-1:0] i_color,
    output logic               o_valid,
    output logic               o_valid_nxt_c,
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic [COLOR_W-1:0] o_color
);

    localparam logic [0:0]     S_IDLE   = 1'(IDLE);
    localparam logic [0:0]     S_FLYING = 1'(FLYING);
    localparam logic [X_W-1:0] X_LAST   = X_W'(GRID_W - 1);

    logic [0:0]         r_state, w_state_nxt;
    logic [X_W-1:0]     r_x, w_x_nxt;
    logic [Y_W-1:0]     r_y, w_y_nxt;
    logic [COLOR_W-1:0] r_color, w_color_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_color <= w_color_nxt;
        end
    end

    // Kill has priority over step; a retired slot keeps its last position and colour
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_color_nxt = r_color;
        case (r_state)
            S_IDLE: begin
                if (i_spawn) begin
                    w_state_nxt = S_FLYING;
                    w_x_nxt     = '0;
                    w_y_nxt     = i_y;
                    w_color_nxt = i_color;
                end
            end
            S_FLYING: begin
                if (i_kill) begin
                    w_state_nxt = S_IDLE;
                end else if (i_step) begin
                    if (r_x == X_LAST) w_state_nxt = S_IDLE;
                    else               w_x_nxt     = r_x + X_W'(1);
                end
            end
        endcase
    end

    assign o_valid       = (r_state == S_FLYING);
    assign o_valid_nxt_c = (w_state_nxt == S_FLYING);
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_color       = r_color;

endmodule

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS projectiles with fire edge detection and step-based cooldown.
// Optional PROJECTILE_STATS_EN adds saturating shots_fired / shots_dropped counters.
module projectile_pool
    import game_pkg::*;
#(
    parameter  int unsigned NUM_SLOTS      = 4,
    parameter  int unsigned GRID_W         = DEF_GRID_W,
    parameter  int unsigned GRID_H         = DEF_GRID_H,
    parameter  int unsigned COLOR_W        = DEF_COLOR_W,
    parameter  int unsigned COOLDOWN_STEPS = 2,
    localparam int unsigned X_W            = clog2_min1(GRID_W),
    localparam int unsigned Y_W            = clog2_min1(GRID_H),
    localparam int unsigned S_W            = clog2_min1(NUM_SLOTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic                         fire,
    input  logic [Y_W-1:0]               fire_y,
    input  logic [COLOR_W-1:0]           fire_color,
    input  logic                         kill_valid,
    input  logic [S_W-1:0]               kill_slot,
    output logic [NUM_SLOTS-1:0]         slot_valid,
    output logic [NUM_SLOTS*X_W-1:0]     slot_x,
    output logic [NUM_SLOTS*Y_W-1:0]     slot_y,
    output logic [NUM_SLOTS*COLOR_W-1:0] slot_color,
    output logic                         fire_accept,
    output logic                         fire_drop,
    output logic                         pool_full
`ifdef PROJECTILE_STATS_EN
    ,
    output logic [7:0]                   shots_fired,
    output logic [7:0]                   shots_dropped
`endif
);

    localparam int unsigned CD_W       = clog2_min1(COOLDOWN_STEPS + 1);
    localparam logic [0:0]  S_READY    = 1'(READY);
    localparam logic [0:0]  S_COOLDOWN = 1'(COOLDOWN);

    logic                 r_fire_q;
    logic [0:0]           r_state, w_state_nxt;
    logic [CD_W-1:0]      r_cnt, w_cnt_nxt;
    logic                 r_accept, r_drop, r_pool_full;
    logic                 w_accept_nxt, w_drop_nxt, w_spawn, w_edge;
    logic                 w_free_found;
    logic [S_W-1:0]       w_free_idx;
    logic [NUM_SLOTS-1:0] w_valid, w_valid_nxt, w_spawn_vec, w_kill_vec;

    assign w_edge = fire & ~r_fire_q;

    // Lowest-index free slot, taken from the current registered valid flags
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = S_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_spawn      = 1'b0;
        w_accept_nxt = 1'b0;
        w_drop_nxt   = 1'b0;
        case (r_state)
            S_READY: begin
                if (w_edge) begin
                    if (w_free_found) begin
                        w_spawn      = 1'b1;
                        w_accept_nxt = 1'b1;
                        if (COOLDOWN_STEPS > 0) begin
                            w_state_nxt = S_COOLDOWN;
                            w_cnt_nxt   = CD_W'(COOLDOWN_STEPS);
                        end
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_COOLDOWN: begin
                w_drop_nxt = w_edge;
                if (step) begin
                    if (r_cnt <= CD_W'(1)) begin
                        w_state_nxt = S_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CD_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fire_q    <= 1'b0;
            r_state     <= S_READY;
            r_cnt       <= '0;
            r_accept    <= 1'b0;
            r_drop      <= 1'b0;
            r_pool_full <= 1'b0;
        end else begin
            r_fire_q    <= fire;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_accept    <= w_accept_nxt;
            r_drop      <= w_drop_nxt;
            r_pool_full <= &w_valid_nxt;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign w_spawn_vec[i] = w_spawn && (w_free_idx == S_W'(i));
        assign w_kill_vec[i]  = kill_valid && (32'(kill_slot) == 32'(i));

        projectile_slot #(
            .GRID_W  (GRID_W),
            .X_W     (X_W),
            .Y_W     (Y_W),
            .COLOR_W (COLOR_W)
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst),
            .i_spawn       (w_spawn_vec[i]),
            .i_step        (step),
            .i_kill        (w_kill_vec[i]),
            .i_y           (fire_y),
            .i_color       (fire_color),
            .o_valid       (w_valid[i]),
            .o_valid_nxt_c (w_valid_nxt[i]),
            .o_x           (slot_x[i*X_W +: X_W]),
            .o_y           (slot_y[i*Y_W +: Y_W]),
            .o_color       (slot_color[i*COLOR_W +: COLOR_W])
        );
    end

    assign slot_valid  = w_valid;
    assign fire_accept = r_accept;
    assign fire_drop   = r_drop;
    assign pool_full   = r_pool_full;

`ifdef PROJECTILE_STATS_EN
    logic [7:0] r_shots_fired, r_shots_dropped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shots_fired   <= '0;
            r_shots_dropped <= '0;
        end else begin
            if (w_accept_nxt && (r_shots_fired != 8'hFF))
                r_shots_fired <= r_shots_fired + 8'd1;
            if (w_drop_nxt && (r_shots_dropped != 8'hFF))
                r_shots_dropped <= r_shots_dropped + 8'd1;
        end
    end

    assign shots_fired   = r_shots_fired;
    assign shots_dropped = r_shots_dropped;
`endif

endmodule

// File: tb/tb_projectile_pool.sv
// Randomised and directed bench for projectile_pool against a per-cycle behavioural model.
module tb_projectile_pool;

    localparam int NS  = 4;
    localparam int GW  = 16;
    localparam int CDS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step = 1'b0;
    logic        fire = 1'b0;
    logic [3:0]  fire_y = '0;
    logic [11:0] fire_color = '0;
    logic        kill_valid = 1'b0;
    logic [1:0]  kill_slot = '0;
    logic [3:0]  slot_valid;
    logic [15:0] slot_x;
    logic [15:0] slot_y;
    logic [47:0] slot_color;
    logic        fire_accept, fire_drop, pool_full;
`ifdef PROJECTILE_STATS_EN
    logic [7:0]  shots_fired, shots_dropped;
`endif

    projectile_pool #(
        .NUM_SLOTS      (NS),
        .GRID_W         (GW),
        .GRID_H         (16),
        .COLOR_W        (12),
        .COOLDOWN_STEPS (CDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .fire        (fire),
        .fire_y      (fire_y),
        .fire_color  (fire_color),
        .kill_valid  (kill_valid),
        .kill_slot   (kill_slot),
        .slot_valid  (slot_valid),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .slot_color  (slot_color),
        .fire_accept (fire_accept),
        .fire_drop   (fire_drop),
        .pool_full   (pool_full)
`ifdef PROJECTILE_STATS_EN
        ,
        .shots_fired   (shots_fired),
        .shots_dropped (shots_dropped)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: projectile list by slot, remaining cooldown steps
    bit m_v [NS];
    int m_x [NS];
    int m_y [NS];
    int m_c [NS];
    int m_cd;
    bit m_fq, m_acc, m_drp;
    int m_fired, m_dropped;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_v[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_c[i] = 0;
        end
        m_cd = 0; m_fq = 1'b0; m_acc = 1'b0; m_drp = 1'b0;
        m_fired = 0; m_dropped = 0;
    endtask

    task automatic model_step();
        bit edge_det;
        bit oldv [NS];
        int free_i;
        int old_cd;
        edge_det = fire && !m_fq;
        m_fq     = fire;
        oldv     = m_v;
        free_i   = -1;
        for (int i = NS - 1; i >= 0; i--) if (!oldv[i]) free_i = i;
        m_acc  = 1'b0;
        m_drp  = 1'b0;
        old_cd = m_cd;
        if (old_cd > 0 && step) m_cd = old_cd - 1;
        for (int i = 0; i < NS; i++) begin
            if (oldv[i]) begin
                if (kill_valid && int'(kill_slot) == i) m_v[i] = 1'b0;
                else if (step) begin
                    if (m_x[i] == GW - 1) m_v[i] = 1'b0;
                    else m_x[i] = m_x[i] + 1;
                end
            end
        end
        if (edge_det) begin
            if (old_cd > 0 || free_i < 0) begin
                m_drp = 1'b1;
            end else begin
                m_acc = 1'b1;
                m_v[free_i] = 1'b1;
                m_x[free_i] = 0;
                m_y[free_i] = int'(fire_y);
                m_c[free_i] = int'(fire_color);
                m_cd = CDS;
            end
        end
        if (m_acc && m_fired < 255)   m_fired++;
        if (m_drp && m_dropped < 255) m_dropped++;
    endtask

    task automatic compare_all();
        logic [3:0]  ev;
        logic [15:0] ex, ey;
        logic [47:0] ec;
        for (int i = 0; i < NS; i++) begin
            ev[i]          = m_v[i];
            ex[i*4 +: 4]   = 4'(m_x[i]);
            ey[i*4 +: 4]   = 4'(m_y[i]);
            ec[i*12 +: 12] = 12'(m_c[i]);
        end
        check("slot_valid", 64'(slot_valid), 64'(ev));
        check("slot_x", 64'(slot_x), 64'(ex));
        check("slot_y", 64'(slot_y), 64'(ey));
        check("slot_color", 64'(slot_color), 64'(ec));
        check("fire_accept", 64'(fire_accept), 64'(m_acc));
        check("fire_drop", 64'(fire_drop), 64'(m_drp));
        check("pool_full", 64'(pool_full), 64'(&ev));
`ifdef PROJECTILE_STATS_EN
        check("shots_fired", 64'(shots_fired), 64'(m_fired));
        check("shots_dropped", 64'(shots_dropped), 64'(m_dropped));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        #1;
        compare_all();
    endtask

    task automatic pulse_step();
        step = 1'b1; tick();
        step = 1'b0; tick();
    endtask

    // Drives one fire edge; returns the accept/drop pulses seen on the following cycle
    task automatic fire_edge(input logic [3:0] y, input logic [11:0] c,
                             output logic acc, output logic drp);
        fire_y = y; fire_color = c; fire = 1'b1;
        tick();
        acc = fire_accept; drp = fire_drop;
        fire = 1'b0;
        tick();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #2;
        model_reset();
        check("async_valid", 64'(slot_valid), 64'(0));
        compare_all();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic acc, drp;
        int   n_acc;
        model_reset();
        #2;
        compare_all();
        tick();
        rst = 1'b1;

        // Held fire gives a single spawn
        n_acc = 0;
        fire_y = 4'd5; fire_color = 12'hF00; fire = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fire_accept) n_acc++;
        end
        fire = 1'b0;
        tick();
        check("p1_accepts", 64'(n_acc), 64'(1));
        check("p1_slot0", {52'(0), slot_color[11:0]}, 64'h F00);
        check("p1_y0", 64'(slot_y[3:0]), 64'(5));

        // Fly to the far edge, then retire
        for (int i = 0; i < 15; i++) pulse_step();
        check("p2_x15", 64'(slot_x[3:0]), 64'(15));
        pulse_step();
        check("p2_retired", 64'(slot_valid[0]), 64'(0));
        check("p2_not_full", 64'(pool_full), 64'(0));

        // Fill the pool, fifth edge is dropped
        for (int i = 0; i < NS; i++) begin
            fire_edge(4'(i + 1), 12'(12'h100 * (i + 1)), acc, drp);
            check("p3_accept", 64'(acc), 64'(1));
            pulse_step(); pulse_step();
        end
        check("p3_full", 64'(pool_full), 64'(1));
        fire_edge(4'd9, 12'hABC, acc, drp);
        check("p3_drop", 64'(drp), 64'(1));
        check("p3_valid", 64'(slot_valid), 64'hF);

        // Kill and step on slot 2 together: kill wins
        for (int i = 0; i < 3; i++) pulse_step();
        check("p4_x7", 64'(slot_x[11:8]), 64'(7));
        kill_valid = 1'b1; kill_slot = 2'd2; step = 1'b1;
        tick();
        kill_valid = 1'b0; step = 1'b0;
        check("p4_killed", 64'(slot_valid[2]), 64'(0));
        check("p4_xhold", 64'(slot_x[11:8]), 64'(7));
        tick();
        fire_edge(4'd3, 12'h0F0, acc, drp);
        check("p4_reuse", 64'(slot_valid[2]), 64'(1));
        check("p4_reuse_x", 64'(slot_x[11:8]), 64'(0));

        // Cooldown: edge after one step dropped, after two accepted into slot 1
        for (int i = 0; i < NS; i++) begin
            kill_valid = 1'b1; kill_slot = 2'(i); tick();
        end
        kill_valid = 1'b0;
        pulse_step(); pulse_step();
        fire_edge(4'd1, 12'h111, acc, drp);
        check("p5_first", 64'(acc), 64'(1));
        pulse_step();
        fire_edge(4'd2, 12'h222, acc, drp);
        check("p5_cd_drop", 64'(drp), 64'(1));
        pulse_step();
        fire_edge(4'd3, 12'h333, acc, drp);
        check("p5_accept", 64'(acc), 64'(1));
        check("p5_slot1", 64'(slot_valid[1]), 64'(1));

        // Asynchronous reset mid-flight with three live slots
        pulse_step(); pulse_step();
        fire_edge(4'd4, 12'h444, acc, drp);
        check("p6_three", 64'(slot_valid), 64'h7);
        async_reset();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) fire = ~fire;
            step       = ($urandom_range(0, 3) == 0);
            kill_valid = ($urandom_range(0, 9) == 0);
            kill_slot  = 2'($urandom_range(0, 3));
            fire_y     = 4'($urandom_range(0, 15));
            fire_color = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
